// File: rtl/elastic_pipe_reg.sv
// Elastic register chain: DEPTH signed stages with per-stage valid, valid/ready
// backpressure, bubble squeeze, synchronous flush and an occupancy counter.

module elastic_pipe_stage #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              rdy,
  input  logic              src_valid,
  input  logic [DWIDTH-1:0] src_data,
  output logic              v,
  output logic [DWIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (reset) begin
      v    <= 1'b0;
      data <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (rdy) begin
      v <= src_valid;
      // data only moves with a real sample so a drained stage keeps its last value
      if (src_valid) data <= src_data;
    end
  end
endmodule

module elastic_pipe_reg #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4,
  parameter int CWIDTH = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CWIDTH-1:0] count
);
  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0][DWIDTH-1:0] data_pipe;
  logic [DEPTH:0]               rdy;
  logic                         accept, emit;

  // A stage can take a new sample if it is empty or everything ahead of it moves.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH-1; i >= 0; i--)
      rdy[i] = ~vld_pipe[i] | rdy[i+1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              src_v;
    logic [DWIDTH-1:0] src_d;
    if (i == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_body
      assign src_v = vld_pipe[i-1];
      assign src_d = data_pipe[i-1];
    end
    elastic_pipe_stage #(.DWIDTH(DWIDTH)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .rdy       (rdy[i]),
      .src_valid (src_v),
      .src_data  (src_d),
      .v         (vld_pipe[i]),
      .data      (data_pipe[i])
    );
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld_pipe[DEPTH-1] & ~flush;
  assign out_data  = data_pipe[DEPTH-1];
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush)      count <= '0;
    else if (accept && !emit) count <= count + CWIDTH'(1);
    else if (emit && !accept) count <= count - CWIDTH'(1);
  end
endmodule

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised, elastic successor to the single enable-gated data register in the perceptron datapath. It is a chain of DEPTH signed DWIDTH-bit register stages with per-stage valid bits and valid/ready backpressure. Empty stages collapse ("bubble squeeze"), there is a synchronous flush, and an occupancy counter is provided. It sits between neuron MAC/activation stages, where a fixed-latency delay must tolerate downstream stalls without losing or duplicating samples.

## Interface
Parameters:
- DWIDTH, 32: data width in bits; data is signed two's complement.
- DEPTH, 4: number of register stages; legal range is DEPTH >= 1.
- CWIDTH, $clog2(DEPTH+1): width of the occupancy counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_data  input  DWIDTH  upstream sample (signed).
- in_valid  input  1  upstream sample present.
- in_ready  output  1  chain accepts in_data this cycle.
- out_data  output  DWIDTH  data of the last stage (stage DEPTH-1).
- out_valid  output  1  last stage holds a valid sample.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  CWIDTH  number of valid stages, in the range 0..DEPTH.

## Operation
- Stages are indexed 0..DEPTH-1. Stage 0 is fed from in_data; stage DEPTH-1 drives out_data.
- Each stage i holds data_i and v_i.
- Stage-ready chain (combinational):
  - rdy_{DEPTH-1} = ~v_{DEPTH-1} | out_ready.
  - rdy_i = ~v_i | rdy_{i+1}.
- Input side:
  - in_ready = rdy_0 & ~flush.
  - Accept occurs when in_valid & in_ready.
- Output side:
  - out_valid = v_{DEPTH-1} & ~flush.
  - Emit occurs when out_valid & out_ready.
- Stage update (no reset, no flush):
  - When rdy_i is 1, v_i loads the valid of its source. The source is in_valid for stage 0 and v_{i-1} otherwise.
  - data_i loads the source data only when rdy_i & source-valid. Otherwise data_i holds.
  - When rdy_i is 0, the stage holds both data_i and v_i.
- Bubble squeeze: a valid sample advances into an empty stage even while out_ready = 0. The chain fills to DEPTH samples before in_ready falls.
- Full with out_ready = 1: in_ready = 1, so accept and emit happen in the same cycle with no lost throughput.
- Flush (priority below reset):
  - All v_i go to 0 on the next edge and count goes to 0.
  - data_i hold their values.
  - No accept or emit occurs in the flush cycle.
- Reset (highest priority):
  - All v_i = 0 and all data_i = 0.
  - count = 0.
  - After the edge, out_valid = 0, out_data = 0 and in_ready = 1.
  - Reset applied mid-stream discards all samples in flight.
- count update:
  - +1 on accept only.
  - -1 on emit only.
  - Unchanged when both or neither occur.
  - count never exceeds DEPTH and never underflows below 0.
- Data passes through bit-exact: no sign extension, truncation or arithmetic.

## Timing
- Latency with out_ready held at 1: a sample accepted at edge N is presented with out_valid = 1 after edge N+DEPTH-1, i.e. it is visible during cycle N+DEPTH.
- Throughput: one sample per cycle sustained, with no bubbles inserted.
- in_ready depends combinationally on out_ready through the DEPTH-stage ready chain. Upstream must not make in_valid depend on in_ready.
- Once in_valid is asserted, upstream holds in_data and in_valid until accepted.
- Once out_valid is asserted, out_data is stable until emit, flush or reset.
- DEPTH = 1 degenerates to a single elastic register with the same rules.

## Test plan
Configuration for all scenarios: DWIDTH = 32, DEPTH = 4.
- Streaming: reset, hold out_ready = 1, stream 1..8 with in_valid = 1 on consecutive cycles.
  - out emits 1..8 on consecutive cycles, the first 3 cycles after the first accept.
  - count steadies at 4.
- Backpressure fill and drain: out_ready = 0, offer 10,11,12,13,14.
  - Exactly 4 values are accepted, then in_ready = 0 and count = 4 while 14 is held.
  - Raise out_ready: emits 10,11,12,13,14 in order with no duplicates.
- Bubble squeeze: send 7, idle 2 cycles, send 8 while out_ready = 0.
  - Both values sit in stages 3 and 2; count = 2.
  - After out_ready rises, 7 and 8 emit back-to-back.
- Signed data and full pass-through: with the chain full and out_ready = 1, send -5 (0xFFFFFFFB) and 0x7FFFFFFF.
  - Both emit bit-exact.
  - in_ready stays 1 and count stays 4 throughout.
- Flush: with count = 3, assert flush for one cycle together with in_valid = 1, in_data = 99.
  - Next cycle: count = 0 and out_valid = 0.
  - 99 is not accepted and never emitted.
- Reset mid-stream: with count = 2, assert reset.
  - Next cycle: out_data = 0, out_valid = 0, count = 0, in_ready = 1.
  - Subsequent traffic behaves as after power-up.
